// File: rtl/encrypt_sequencer.sv
// encrypt_sequencer
//   Front end for an external block encrypter. Buffers plaintext words
//   in a small FIFO. Programs the key into the encrypter. Issues one word
//   at a time with a rotating key offset. Holds each ciphertext until the
//   consumer accepts it.
//
// Ports
//   clk, reset       single clock; reset is synchronous and active-low
//   keyIn, keyLoad   key value and one-cycle key load request
//   wordIn, wordValid, wordReady     plaintext push (valid/ready)
//   result, resultValid, resultReady ciphertext output (valid/ready)
//   dataIn, rot_offset, prog, dataRdyIn, cap   drive the encrypter
//   rdyIn, dataRdyOut, dataOut                 returned by the encrypter
//   keyDropped       sticky flag: a keyLoad arrived while busy
//   wordsDone        count of completed words, wraps at 16 bits
//
// state        | meaning
// IDLE         | no key loaded; words may be buffered but are not issued
// LOAD_KEY     | prog pulse, dataIn carries the key
// WAIT_KEY     | wait for the encrypter to accept the key
// WAIT_WORD    | key present; issue the FIFO head when the encrypter is ready
// ISSUE        | dataRdyIn pulse with the word and rot_offset
// WAIT_RESULT  | wait for dataRdyOut, then latch dataOut
// HOLD_RESULT  | resultValid held until resultReady
// CAPTURE      | cap pulse; advance rot_offset and wordsDone
module encrypt_sequencer #(
  parameter int ENCRYPTER_WIDTH    = 32,
  parameter int KEY_ROTATION_WIDTH = 5,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ENCRYPTER_WIDTH-1:0]    keyIn,
  input  logic                          keyLoad,
  input  logic [ENCRYPTER_WIDTH-1:0]    wordIn,
  input  logic                          wordValid,
  output logic                          wordReady,
  output logic [ENCRYPTER_WIDTH-1:0]    result,
  output logic                          resultValid,
  input  logic                          resultReady,
  output logic [ENCRYPTER_WIDTH-1:0]    dataIn,
  output logic [KEY_ROTATION_WIDTH-1:0] rot_offset,
  output logic                          prog,
  output logic                          dataRdyIn,
  output logic                          cap,
  input  logic                          rdyIn,
  input  logic                          dataRdyOut,
  input  logic [ENCRYPTER_WIDTH-1:0]    dataOut,
  output logic                          keyDropped,
  output logic [15:0]                   wordsDone
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    WAIT_KEY,
    WAIT_WORD,
    ISSUE,
    WAIT_RESULT,
    HOLD_RESULT,
    CAPTURE
  } state_t;

  state_t state, state_next;

  // plaintext FIFO
  logic [ENCRYPTER_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           count_next;
  logic                       push;
  logic                       pop;

  logic key_loaded, key_loaded_next;

  // next values for the registered outputs
  logic                          prog_next;
  logic                          data_rdy_in_next;
  logic                          cap_next;
  logic [ENCRYPTER_WIDTH-1:0]    data_in_next;
  logic [KEY_ROTATION_WIDTH-1:0] rot_next;
  logic [ENCRYPTER_WIDTH-1:0]    result_next;
  logic                          result_valid_next;
  logic [15:0]                   words_next;
  logic                          dropped_next;
  logic                          word_ready_next;

  // wordReady is registered from the occupancy after this cycle's
  // push/pop, so a push is never accepted into a full FIFO.
  assign push       = wordValid & wordReady;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign word_ready_next = (count_next != CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_next        = state;
    prog_next         = 1'b0;
    data_rdy_in_next  = 1'b0;
    cap_next          = 1'b0;
    data_in_next      = dataIn;
    rot_next          = rot_offset;
    result_next       = result;
    result_valid_next = resultValid;
    words_next        = wordsDone;
    key_loaded_next   = key_loaded;
    dropped_next      = keyDropped;
    pop               = 1'b0;

    case (state)
      IDLE: begin
        if (keyLoad) begin
          state_next   = LOAD_KEY;
          prog_next    = 1'b1;
          data_in_next = keyIn;
          rot_next     = '0;
        end
      end
      LOAD_KEY: begin
        key_loaded_next = 1'b1;
        state_next      = WAIT_KEY;
      end
      WAIT_KEY: begin
        if (rdyIn) state_next = WAIT_WORD;
      end
      WAIT_WORD: begin
        // a new key takes priority over issuing the next word
        if (keyLoad) begin
          state_next   = LOAD_KEY;
          prog_next    = 1'b1;
          data_in_next = keyIn;
          rot_next     = '0;
        end else if (key_loaded && (count != '0) && rdyIn) begin
          state_next       = ISSUE;
          pop              = 1'b1;
          data_in_next     = fifo_mem[rd_ptr];
          data_rdy_in_next = 1'b1;
        end
      end
      ISSUE: begin
        state_next = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (dataRdyOut) begin
          result_next       = dataOut;
          result_valid_next = 1'b1;
          state_next        = HOLD_RESULT;
        end
      end
      HOLD_RESULT: begin
        if (resultReady) begin
          result_valid_next = 1'b0;
          cap_next          = 1'b1;
          state_next        = CAPTURE;
        end
      end
      CAPTURE: begin
        // dataIn/rot_offset were frozen since ISSUE; advance on exit
        rot_next   = rot_offset + KEY_ROTATION_WIDTH'(1);
        words_next = wordsDone + 16'd1;
        state_next = WAIT_WORD;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (keyLoad && (state != IDLE) && (state != WAIT_WORD))
      dropped_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      key_loaded  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wordReady   <= 1'b1;
      result      <= '0;
      resultValid <= 1'b0;
      dataIn      <= '0;
      rot_offset  <= '0;
      prog        <= 1'b0;
      dataRdyIn   <= 1'b0;
      cap         <= 1'b0;
      keyDropped  <= 1'b0;
      wordsDone   <= '0;
    end else begin
      state       <= state_next;
      key_loaded  <= key_loaded_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_next;
      wordReady   <= word_ready_next;
      result      <= result_next;
      resultValid <= result_valid_next;
      dataIn      <= data_in_next;
      rot_offset  <= rot_next;
      prog        <= prog_next;
      dataRdyIn   <= data_rdy_in_next;
      cap         <= cap_next;
      keyDropped  <= dropped_next;
      wordsDone   <= words_next;
    end
  end

  // storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wordIn;
  end

endmodule

// File: tb/tb_encrypt_sequencer.sv
// Directed bench for encrypt_sequencer. Includes a behavioural encrypter
// that computes word ^ rotl(key, rot) after a fixed latency.
module tb_encrypt_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] keyIn;
  logic        keyLoad;
  logic [31:0] wordIn;
  logic        wordValid;
  logic        wordReady;
  logic [31:0] result;
  logic        resultValid;
  logic        resultReady;
  logic [31:0] dataIn;
  logic [4:0]  rot_offset;
  logic        prog;
  logic        dataRdyIn;
  logic        cap;
  logic        rdyIn;
  logic        dataRdyOut;
  logic [31:0] dataOut;
  logic        keyDropped;
  logic [15:0] wordsDone;

  int errors = 0;
  int checks = 0;

  encrypt_sequencer #(
    .ENCRYPTER_WIDTH(32),
    .KEY_ROTATION_WIDTH(5),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .keyIn(keyIn), .keyLoad(keyLoad),
    .wordIn(wordIn), .wordValid(wordValid), .wordReady(wordReady),
    .result(result), .resultValid(resultValid), .resultReady(resultReady),
    .dataIn(dataIn), .rot_offset(rot_offset), .prog(prog),
    .dataRdyIn(dataRdyIn), .cap(cap),
    .rdyIn(rdyIn), .dataRdyOut(dataRdyOut), .dataOut(dataOut),
    .keyDropped(keyDropped), .wordsDone(wordsDone)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
    if (s == 0) return v;
    return (v << s) | (v >> (32 - s));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // behavioural encrypter
  logic [31:0] enc_key = '0;
  logic [31:0] enc_d   = '0;
  logic [4:0]  enc_r   = '0;
  int          enc_cnt = 0;
  assign rdyIn = (enc_cnt == 0);

  always @(posedge clk) begin
    dataRdyOut <= 1'b0;
    if (prog) enc_key <= dataIn;
    if (dataRdyIn) begin
      enc_d   <= dataIn;
      enc_r   <= rot_offset;
      enc_cnt <= 3;
    end else if (enc_cnt > 0) begin
      enc_cnt <= enc_cnt - 1;
      if (enc_cnt == 1) begin
        dataRdyOut <= 1'b1;
        dataOut    <= enc_d ^ rotl(enc_key, int'(enc_r));
      end
    end
  end

  // monitors
  logic [31:0] res_q[$];
  logic [4:0]  rot_q[$];
  int          prog_cnt  = 0;
  int          issue_cnt = 0;
  int          cap_cnt   = 0;
  int          pulse_viol = 0;
  logic [31:0] key_seen = '0;
  logic        prev_p = 1'b0, prev_d = 1'b0, prev_c = 1'b0;

  always @(posedge clk) begin
    if (resultValid && resultReady) res_q.push_back(result);
    if (dataRdyIn) begin
      rot_q.push_back(rot_offset);
      issue_cnt++;
    end
    if (prog) begin
      prog_cnt++;
      key_seen = dataIn;
    end
    if (cap) cap_cnt++;
    if (int'(prog) + int'(dataRdyIn) + int'(cap) > 1) pulse_viol++;
    if ((prog && prev_p) || (dataRdyIn && prev_d) || (cap && prev_c)) pulse_viol++;
    prev_p = prog;
    prev_d = dataRdyIn;
    prev_c = cap;
  end

  task automatic check_reset_state();
    chk("rst_ctl", 32'({prog, dataRdyIn, cap, resultValid, keyDropped, wordReady}), 32'h1);
    chk("rst_data_in", dataIn, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_rot", 32'(rot_offset), 32'h0);
    chk("rst_words", 32'(wordsDone), 32'h0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();
    reset = 1'b1;
  endtask

  task automatic load_key(input logic [31:0] k);
    repeat (2) @(negedge clk);
    keyLoad = 1'b1;
    keyIn   = k;
    @(negedge clk);
    keyLoad = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    wordValid = 1'b1;
    wordIn    = w;
    while (!wordReady && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(wordReady), 32'h1);
    @(negedge clk);
    wordValid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int t;
    t = 0;
    while (res_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("result_count", 32'(res_q.size()), 32'(n));
  endtask

  logic [31:0] vec[5] = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0};
  logic [31:0] exp4[4] = '{32'hA1, 32'hB2, 32'hC4, 32'hD8};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, ib, pb, cb, acc, bad, t;
    reset = 1'b0; keyIn = '0; keyLoad = 1'b0; wordIn = '0;
    wordValid = 1'b0; resultReady = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b1;

    // single word, key 0xFF
    pb = prog_cnt; rb = res_q.size(); ib = rot_q.size();
    load_key(32'h000000FF);
    repeat (3) @(negedge clk);
    chk("prog_pulses", 32'(prog_cnt - pb), 32'h1);
    chk("prog_key", key_seen, 32'h000000FF);
    push(32'h12345678);
    wait_results(rb + 1);
    chk("w1_result", res_q[rb], 32'h12345687);
    chk("w1_rot", 32'(rot_q[ib]), 32'h0);
    repeat (3) @(negedge clk);
    chk("w1_words", 32'(wordsDone), 32'h1);

    // two zero words after a fresh key load
    rb = res_q.size(); ib = rot_q.size();
    load_key(32'h000000FF);
    push(32'h0);
    push(32'h0);
    wait_results(rb + 2);
    chk("w2_res0", res_q[rb], 32'h000000FF);
    chk("w2_res1", res_q[rb + 1], 32'h000001FE);
    chk("w2_rot0", 32'(rot_q[ib]), 32'h0);
    chk("w2_rot1", 32'(rot_q[ib + 1]), 32'h1);

    // 33 words: rotation wraps from 31 back to 0
    rb = res_q.size(); ib = rot_q.size();
    load_key(32'h000000FF);
    for (int i = 0; i < 33; i++) push(32'h0);
    wait_results(rb + 33);
    for (int i = 0; i < 33; i++) begin
      chk("rot_seq", 32'(rot_q[ib + i]), 32'(i % 32));
      chk("rot_res", res_q[rb + i], rotl(32'h000000FF, i % 32));
    end
    repeat (3) @(negedge clk);
    chk("words_36", 32'(wordsDone), 32'd36);

    // no key: FIFO fills, nothing issued, then drains in order
    reset_dut();
    ib = issue_cnt; acc = 0;
    @(negedge clk);
    wordValid = 1'b1;
    wordIn = vec[0];
    for (int c = 0; c < 8; c++) begin
      if (wordValid && wordReady) acc++;
      @(negedge clk);
      if (acc < 5) wordIn = vec[acc];
      else wordValid = 1'b0;
    end
    chk("full_ready", 32'(wordReady), 32'h0);
    wordValid = 1'b0;
    chk("full_accepts", 32'(acc), 32'd4);
    repeat (10) @(negedge clk);
    chk("nokey_issue", 32'(issue_cnt - ib), 32'h0);
    rb = res_q.size();
    load_key(32'h00000001);
    wait_results(rb + 4);
    for (int i = 0; i < 4; i++) chk("drain_order", res_q[rb + i], exp4[i]);
    chk("nodrop_yet", 32'(keyDropped), 32'h0);

    // consumer stall with a keyLoad arriving mid-hold (key 1, rot now 4)
    resultReady = 1'b0;
    rb = res_q.size();
    push(32'h0);
    t = 0;
    while (!resultValid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("hold_valid", 32'(resultValid), 32'h1);
    chk("hold_result", result, 32'h00000010);
    cb = cap_cnt; pb = prog_cnt; bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin keyLoad = 1'b1; keyIn = 32'hDEADBEEF; end
      if (c == 4) keyLoad = 1'b0;
      @(negedge clk);
      if (!resultValid || result !== 32'h00000010) bad++;
    end
    chk("hold_stable", 32'(bad), 32'h0);
    chk("hold_nocap", 32'(cap_cnt - cb), 32'h0);
    chk("key_dropped", 32'(keyDropped), 32'h1);
    chk("dropped_noprog", 32'(prog_cnt - pb), 32'h0);
    resultReady = 1'b1;
    wait_results(rb + 1);
    chk("stall_res", res_q[rb], 32'h00000010);
    repeat (2) @(negedge clk);
    chk("stall_cap", 32'(cap_cnt - cb), 32'h1);
    push(32'h0);
    wait_results(rb + 2);
    chk("key_kept", res_q[rb + 1], 32'h00000020);

    // reset while waiting for the encrypter
    push(32'h11);
    push(32'h22);
    t = 0;
    while (!dataRdyIn && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("saw_issue", 32'(dataRdyIn), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();
    reset = 1'b1;
    rb = res_q.size(); ib = issue_cnt;
    push(32'h33);
    repeat (20) @(negedge clk);
    chk("post_rst_noissue", 32'(issue_cnt - ib), 32'h0);
    load_key(32'h0);
    wait_results(rb + 1);
    chk("post_rst_res", res_q[rb], 32'h33);
    repeat (20) @(negedge clk);
    chk("post_rst_only", 32'(res_q.size()), 32'(rb + 1));
    chk("pulse_rules", 32'(pulse_viol), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
